// File: rtl/aes_dec_sequencer_pkg.sv
// Shared types and sizing for the byte-serial AES decrypt sequencer.
package aes_dec_sequencer_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
  // Stream counter spans 0..KEY_LAG+15, so KEY_LAG must not exceed 16.
  localparam int unsigned CNT_W       = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_KEY_TAIL,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_t;

endpackage

// File: rtl/aes_dec_sequencer_if.sv
// Block-level input (ciphertext/key) and output (plaintext) valid/ready bus.
interface aes_dec_sequencer_if
  import aes_dec_sequencer_pkg::*;
;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic [BLOCK_W-1:0] in_key;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_dec_sequencer_byte_shifter.sv
// Block-wide register with parallel load and byte shift toward the MSB end.
module aes_dec_sequencer_byte_shifter
  import aes_dec_sequencer_pkg::*;
#(
  parameter int unsigned W = BLOCK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [W-1:0]      par_in,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [W-1:0]      q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= par_in;
    else if (shift) q <= {q[W-BYTE_W-1:0], byte_in};
  end

endmodule

// File: rtl/aes_dec_sequencer.sv
// Controller for the byte-serial AES decrypt core: skewed ciphertext/key streaming
// and plaintext collection. Optional watchdog enabled by AES_DEC_TIMEOUT_EN.
module aes_dec_sequencer
  import aes_dec_sequencer_pkg::*;
#(
  parameter int unsigned KEY_LAG = 12
`ifdef AES_DEC_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_dec_sequencer_if.slave   bus,
  output logic                 busy,
  output logic                 err,
  output logic                 core_en,
  output logic [BYTE_W-1:0]    core_data,
  output logic [BYTE_W-1:0]    core_key,
  input  logic [BYTE_W-1:0]    core_out,
  input  logic                 core_ovld
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(KEY_LAG + BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] KEY_FIRST = CNT_W'(KEY_LAG);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(BLOCK_BYTES);
  localparam logic [3:0]       LAST_BYTE = 4'(BLOCK_BYTES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         ccnt;
  logic               in_ready_q, out_valid_q;
  logic               hs, stream_adv, data_emit, key_emit, cap, finishing;
  logic               wd_fire, wd_expire;
  logic [BLOCK_W-1:0] data_q, key_q, col_q;
  logic               unused_bits;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = col_q;
  assign unused_bits   = ^{data_q[BLOCK_W-BYTE_W-1:0], key_q[BLOCK_W-BYTE_W-1:0]};

  assign hs        = bus.in_valid && in_ready_q;
  assign cap       = core_ovld && !wd_expire &&
                     (state == S_KEY_TAIL || state == S_WAIT || state == S_COLLECT);
  assign finishing = cap && state == S_COLLECT && ccnt == LAST_BYTE;

  // The key tail keeps streaming even if the core starts returning bytes early.
  always_comb begin
    stream_adv = 1'b0;
    cnt_nxt    = cnt;
    case (state)
      S_START: begin
        stream_adv = 1'b1;
        cnt_nxt    = '0;
      end
      S_LOAD, S_KEY_TAIL, S_COLLECT: begin
        if (cnt != LAST_CNT) begin
          stream_adv = 1'b1;
          cnt_nxt    = cnt + 1'b1;
        end
      end
      default: ;
    endcase
    data_emit = stream_adv && (cnt_nxt < DATA_END);
    key_emit  = stream_adv && (cnt_nxt >= KEY_FIRST);
  end

  aes_dec_sequencer_byte_shifter #(.W(BLOCK_W)) u_data_sh (
    .clk(clk), .rst(rst), .load(hs), .shift(data_emit),
    .par_in(bus.in_data), .byte_in('0), .q(data_q)
  );

  aes_dec_sequencer_byte_shifter #(.W(BLOCK_W)) u_key_sh (
    .clk(clk), .rst(rst), .load(hs), .shift(key_emit),
    .par_in(bus.in_key), .byte_in('0), .q(key_q)
  );

  aes_dec_sequencer_byte_shifter #(.W(BLOCK_W)) u_col_sh (
    .clk(clk), .rst(rst), .load(1'b0), .shift(cap),
    .par_in('0), .byte_in(core_out), .q(col_q)
  );

`ifdef AES_DEC_TIMEOUT_EN
  logic [11:0] wd;
  logic        wd_active;

  assign wd_active = (state == S_WAIT || state == S_COLLECT);
  // err is registered, so it is raised one cycle ahead of the abort.
  assign wd_fire   = wd_active && wd == 12'(TIMEOUT_CYCLES - 2) && !finishing;
  assign wd_expire = wd_active && wd == 12'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wd <= '0;
    else if (wd_active) wd <= wd + 1'b1;
    else                wd <= '0;
  end
`else
  assign wd_fire   = 1'b0;
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ccnt        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      core_en     <= 1'b0;
      core_data   <= '0;
      core_key    <= '0;
    end else begin
      core_en   <= 1'b0;
      err       <= wd_fire;
      cnt       <= cnt_nxt;
      core_data <= data_emit ? data_q[BLOCK_W-1 -: BYTE_W] : '0;
      core_key  <= key_emit  ? key_q[BLOCK_W-1 -: BYTE_W]  : '0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            state      <= S_START;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            core_en    <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_START: begin
          err   <= core_ovld;
          state <= S_LOAD;
        end
        S_LOAD: begin
          err <= core_ovld;
          if (cnt == LAST_CNT)        state <= S_WAIT;
          else if (cnt_nxt >= DATA_END) state <= S_KEY_TAIL;
        end
        S_KEY_TAIL: begin
          if (cap) begin
            state <= S_COLLECT;
            ccnt  <= 4'd1;
          end else if (cnt == LAST_CNT) begin
            state <= S_WAIT;
          end
        end
        S_WAIT, S_COLLECT: begin
          if (wd_expire) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            in_ready_q <= 1'b1;
          end else if (cap) begin
            if (state == S_WAIT) begin
              state <= S_COLLECT;
              ccnt  <= 4'd1;
            end else if (finishing) begin
              state       <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              ccnt <= ccnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
